// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, drives imem_addr, captures IF/ID (1-edge latency, 1 instr/cycle);
// stall freezes PC and IF/ID, flush/branch insert bubbles. FETCH_HALT_EN: 16'hFFFF halts fetch.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned PC_STEP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus2,
  output logic        ifid_valid,
  output logic        halted
);

  localparam logic [15:0] STEP       = PC_STEP[15:0];
  localparam logic [15:0] HALT_INSTR = 16'hFFFF;

  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_plus2_q, pc_plus2_d;
  logic        valid_q, valid_d;
  logic [15:0] pc_seq;
  logic        normal_edge;
  logic        halt_active;
  logic        halt_capture;

  // Carry out of the increment is intentionally dropped (16-bit wrap).
  assign pc_seq      = pc_q + STEP;
  assign normal_edge = !branch_taken && !flush && !stall;

`ifdef FETCH_HALT_EN
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (branch_taken) begin
      state_d = ST_RUN;
    end else if (normal_edge && (state_q == ST_RUN) && (imem_instr == HALT_INSTR)) begin
      state_d = ST_HALT;
    end
  end

  always_comb begin
    halt_active  = (state_q == ST_HALT);
    halt_capture = normal_edge && (state_q == ST_RUN) && (imem_instr == HALT_INSTR);
    halted       = halt_active;
  end
`else
  assign halt_active  = 1'b0;
  assign halt_capture = 1'b0;
  assign halted       = 1'b0;
`endif

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus2_d = pc_plus2_q;
    valid_d    = valid_q;
    if (branch_taken) begin
      pc_d       = {branch_target[15:1], 1'b0};
      instr_d    = 16'h0000;
      pc_plus2_d = 16'h0000;
      valid_d    = 1'b0;
    end else if (flush) begin
      instr_d    = 16'h0000;
      pc_plus2_d = 16'h0000;
      valid_d    = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (halt_active) begin
      instr_d    = 16'h0000;
      pc_plus2_d = 16'h0000;
      valid_d    = 1'b0;
    end else begin
      // The halt word itself is delivered, but the PC parks on its address.
      pc_d       = halt_capture ? pc_q : pc_seq;
      instr_d    = imem_instr;
      pc_plus2_d = pc_seq;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      instr_q    <= 16'h0000;
      pc_plus2_q <= 16'h0000;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus2_q <= pc_plus2_d;
      valid_q    <= valid_d;
    end
  end

  assign imem_addr     = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc_plus2 = pc_plus2_q;
  assign ifid_valid    = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory word at address k is k (optionally 16'hFFFF at 0x000A);
// expected IF/ID + PC + halted pushed to a queue per edge, popped and compared after it.
module tb_fetch_unit;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pp2;
    logic        valid;
    logic [15:0] pc;
    logic        halted;
  } obs_t;

  logic        clk;
  logic        rst;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        halted;
  logic        halt_word_en;

  int   errors;
  int   checks;
  obs_t exp_q[$];
  obs_t got;
  obs_t e;

  fetch_unit #(
    .RESET_PC(16'h0000),
    .PC_STEP (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .stall        (stall),
    .flush        (flush),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .ifid_instr   (ifid_instr),
    .ifid_pc_plus2(ifid_pc_plus2),
    .ifid_valid   (ifid_valid),
    .halted       (halted)
  );

  assign imem_instr = (halt_word_en && imem_addr == 16'h000A) ? 16'hFFFF : imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t sample();
    return {ifid_instr, ifid_pc_plus2, ifid_valid, imem_addr, halted};
  endfunction

  function automatic obs_t mk(input logic [15:0] instr, input logic [15:0] pp2,
                              input logic valid, input logic [15:0] pc, input logic h);
    return {instr, pp2, valid, pc, h};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #2;
    got = sample();
    checks++;
    if (got !== mk(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0)) begin
      errors++;
      $display("FAIL reset got=%h exp=%h", got, mk(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0));
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(mk(16'(2 * k), 16'(2 * k + 2), 1'b1, 16'(2 * k + 2), 1'b0));
      @(posedge clk); #1;
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL free_run[%0d] got=%h exp=%h", k, got, e);
      end
    end
  endtask

  task automatic test_stall();
    obs_t tbl[6];
    logic br[6];
    logic st[6];
    br = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    st = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[0] = mk(16'h0000, 16'h0000, 1'b0, 16'h0004, 1'b0);
    tbl[1] = mk(16'h0004, 16'h0006, 1'b1, 16'h0006, 1'b0);
    tbl[2] = tbl[1];
    tbl[3] = tbl[1];
    tbl[4] = tbl[1];
    tbl[5] = mk(16'h0006, 16'h0008, 1'b1, 16'h0008, 1'b0);
    branch_target = 16'h0004;
    for (int k = 0; k < 6; k++) begin
      branch_taken = br[k];
      stall        = st[k];
      exp_q.push_back(tbl[k]);
      @(posedge clk); #1;
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL stall[%0d] got=%h exp=%h", k, got, e);
      end
    end
    branch_taken = 1'b0;
    stall        = 1'b0;
  endtask

  task automatic test_flush();
    obs_t tbl[4];
    logic fl[4];
    logic st[4];
    fl = '{1'b1, 1'b0, 1'b1, 1'b0};
    st = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[0] = mk(16'h0000, 16'h0000, 1'b0, 16'h0008, 1'b0);
    tbl[1] = mk(16'h0008, 16'h000A, 1'b1, 16'h000A, 1'b0);
    tbl[2] = mk(16'h0000, 16'h0000, 1'b0, 16'h000A, 1'b0);
    tbl[3] = mk(16'h000A, 16'h000C, 1'b1, 16'h000C, 1'b0);
    for (int k = 0; k < 4; k++) begin
      flush = fl[k];
      stall = st[k];
      exp_q.push_back(tbl[k]);
      @(posedge clk); #1;
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL flush[%0d] got=%h exp=%h", k, got, e);
      end
    end
    flush = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_branch_vs_stall();
    branch_taken  = 1'b1;
    stall         = 1'b1;
    branch_target = 16'h0041;
    exp_q.push_back(mk(16'h0000, 16'h0000, 1'b0, 16'h0040, 1'b0));
    @(posedge clk); #1;
    branch_taken = 1'b0;
    stall        = 1'b0;
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL branch_stall_bubble got=%h exp=%h", got, e);
    end
    exp_q.push_back(mk(16'h0040, 16'h0042, 1'b1, 16'h0042, 1'b0));
    @(posedge clk); #1;
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL branch_stall_target got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_wrap();
    branch_taken  = 1'b1;
    branch_target = 16'hFFFE;
    exp_q.push_back(mk(16'h0000, 16'h0000, 1'b0, 16'hFFFE, 1'b0));
    @(posedge clk); #1;
    branch_taken = 1'b0;
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL wrap_bubble got=%h exp=%h", got, e);
    end
    exp_q.push_back(mk(16'hFFFE, 16'h0000, 1'b1, 16'h0000, 1'b0));
    @(posedge clk); #1;
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL wrap_capture got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_halt();
    obs_t tbl[9];
    logic br[9];
    halt_word_en  = 1'b1;
    branch_target = 16'h0008;
    br = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[0] = mk(16'h0000, 16'h0000, 1'b0, 16'h0008, 1'b0);
    tbl[1] = mk(16'h0008, 16'h000A, 1'b1, 16'h000A, 1'b0);
`ifdef FETCH_HALT_EN
    tbl[2] = mk(16'hFFFF, 16'h000C, 1'b1, 16'h000A, 1'b1);
    for (int k = 3; k < 8; k++) tbl[k] = mk(16'h0000, 16'h0000, 1'b0, 16'h000A, 1'b1);
`else
    tbl[2] = mk(16'hFFFF, 16'h000C, 1'b1, 16'h000C, 1'b0);
    for (int k = 3; k < 8; k++)
      tbl[k] = mk(16'(2 * k + 6), 16'(2 * k + 8), 1'b1, 16'(2 * k + 8), 1'b0);
`endif
    tbl[8] = mk(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    for (int k = 0; k < 9; k++) begin
      branch_taken = br[k];
      if (k == 8) branch_target = 16'h0000;
      exp_q.push_back(tbl[k]);
      @(posedge clk); #1;
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL halt[%0d] got=%h exp=%h", k, got, e);
      end
    end
    branch_taken = 1'b0;
    halt_word_en = 1'b0;
  endtask

  task automatic test_async_reset();
    branch_taken  = 1'b1;
    branch_target = 16'h000E;
    @(posedge clk); #1;
    branch_taken = 1'b0;
    exp_q.push_back(mk(16'h000E, 16'h0010, 1'b1, 16'h0010, 1'b0));
    @(posedge clk); #1;
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL pre_reset got=%h exp=%h", got, e);
    end
    // Reset pulses between edges while a branch request is pending.
    branch_taken  = 1'b1;
    branch_target = 16'h0100;
    #2 rst = 1'b1;
    #1;
    got = sample(); checks++;
    if (got !== mk(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0)) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", got, mk(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0));
    end
    #2 rst = 1'b0;
    branch_taken = 1'b0;
    exp_q.push_back(mk(16'h0000, 16'h0002, 1'b1, 16'h0002, 1'b0));
    @(posedge clk); #1;
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL post_reset got=%h exp=%h", got, e);
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    stall         = 1'b0;
    flush         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;
    halt_word_en  = 1'b0;
    test_reset();
    test_free_run();
    test_stall();
    test_flush();
    test_branch_vs_stall();
    test_wrap();
    test_halt();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
